// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared state type, count width and gray helper for seq_detector
package seq_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int CNT_W = 16;

  function automatic logic [31:0] gray(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/seq_detector_sync2.sv
// rtl/seq_detector_sync2.sv - two-flop synchronizer for the asynchronous symbol bus
module sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - detects a programmable symbol sequence on a synchronized asynchronous bus
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int OVERLAP = 1,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             busy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WIDTH-1:0] sym;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pat [DEPTH];
  logic             ev;
  logic             hit;
  logic [IW-1:0]    nidx;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt_q;
  state_t           state;

  sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (in),
    .q    (sym)
  );

  // Only a change of the synchronized value is a symbol; holding a value is silence.
  assign ev      = (sym != prev);
  assign hit_cnt = cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        pat[k] <= WIDTH'(gray(32'(k % (1 << WIDTH))));
      end
    end else begin
      prev <= sym;
      if (cfg_we && !en && (int'(cfg_idx) < DEPTH)) begin
        pat[cfg_idx] <= cfg_data;
      end
    end
  end

  // A symbol that breaks the run may itself be the first symbol of a new attempt.
  always_comb begin
    hit  = 1'b0;
    nidx = '0;
    if (sym == pat[idx]) begin
      if (idx == IW'(DEPTH - 1)) begin
        hit  = 1'b1;
        nidx = ((OVERLAP != 0) && (sym == pat[0])) ? IW'(1) : '0;
      end else begin
        nidx = idx + IW'(1);
      end
    end else begin
      nidx = (sym == pat[0]) ? IW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
      timer <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      cnt_q <= '0;
    end else begin
      out <= 1'b0;
      if (!en) begin
        state <= IDLE;
        idx   <= '0;
        timer <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= HUNT;
            idx   <= '0;
            timer <= '0;
            busy  <= 1'b0;
          end
          default: begin
            if (ev) begin
              timer <= '0;
              idx   <= nidx;
              busy  <= (nidx != '0);
              state <= (nidx != '0) ? RUN : HUNT;
              if (hit) begin
                out <= 1'b1;
                if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                end
              end
            end else if ((state == RUN) && (TIMEOUT != 0)) begin
              // A stalled partial match is abandoned after TIMEOUT silent cycles.
              if (timer == TW'(TIMEOUT - 1)) begin
                timer <= '0;
                idx   <= '0;
                busy  <= 1'b0;
                state <= HUNT;
              end else begin
                timer <= timer + TW'(1);
              end
            end else begin
              timer <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector, overlapping and non-overlapping instances
`timescale 1ns/1ps
module tb_seq_detector;
  import seq_detector_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  din = 2'd0;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = 2'd0;
  logic [1:0]  cfg_data = 2'd0;
  logic        out1, busy1, out0, busy0;
  logic [15:0] hit1, hit0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp1[$];
  int exp0[$];

  logic [1:0] mpat [4];
  logic [1:0] last;
  int midx1, midx0, mhit1, mhit0;

  seq_detector #(.WIDTH(2), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .OVERLAP(1)) dut1 (
    .clk(clk), .rstn(rstn), .in(din), .en(en), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .out(out1), .hit_cnt(hit1), .busy(busy1)
  );

  seq_detector #(.WIDTH(2), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .OVERLAP(0)) dut0 (
    .clk(clk), .rstn(rstn), .in(din), .en(en), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .out(out0), .hit_cnt(hit0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses are popped from the scoreboard as the DUTs produce them.
  always @(negedge clk) begin
    if (exp1.size() > 0 && exp1[0] == cyc) begin
      total++;
      if (out1 !== 1'b1) begin
        bad++;
        $display("FAIL pulse_ovl1 cyc=%0d out=%b expected 1", cyc, out1);
      end
      void'(exp1.pop_front());
    end else if (rstn === 1'b1 && out1 !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL stray_pulse_ovl1 cyc=%0d out=%b expected 0", cyc, out1);
    end
    if (exp0.size() > 0 && exp0[0] == cyc) begin
      total++;
      if (out0 !== 1'b1) begin
        bad++;
        $display("FAIL pulse_ovl0 cyc=%0d out=%b expected 1", cyc, out0);
      end
      void'(exp0.pop_front());
    end else if (rstn === 1'b1 && out0 !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL stray_pulse_ovl0 cyc=%0d out=%b expected 0", cyc, out0);
    end
  end

  function automatic int model_next(input int idx, input logic [1:0] s, input bit ovl,
                                    output bit hit);
    hit = 1'b0;
    if (s == mpat[idx]) begin
      if (idx == DEPTH - 1) begin
        hit = 1'b1;
        return (ovl && s == mpat[0]) ? 1 : 0;
      end
      return idx + 1;
    end
    return (s == mpat[0]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    mpat[0] = 2'd0; mpat[1] = 2'd1; mpat[2] = 2'd3; mpat[3] = 2'd2;
    last = 2'd0;
    midx1 = 0; midx0 = 0; mhit1 = 0; mhit0 = 0;
    exp1.delete();
    exp0.delete();
  endtask

  // Drive one symbol at a falling edge, hold it, and predict pulses three edges later.
  task automatic drive_sym(input logic [1:0] s, input int hold);
    bit h;
    din = s;
    if (s != last) begin
      last = s;
      midx1 = model_next(midx1, s, 1'b1, h);
      if (h) begin
        exp1.push_back(cyc + 3);
        if (mhit1 < 16'hFFFF) mhit1++;
      end
      midx0 = model_next(midx0, s, 1'b0, h);
      if (h) begin
        exp0.push_back(cyc + 3);
        if (mhit0 < 16'hFFFF) mhit0++;
      end
      if (TIMEOUT != 0 && hold - 1 >= TIMEOUT) begin
        midx1 = 0;
        midx0 = 0;
      end
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rstn = 1'b0; din = 2'd0; en = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out1 !== 1'b0 || busy1 !== 1'b0 || hit1 !== 16'd0) begin
      bad++;
      $display("FAIL reset_hold out=%b busy=%b hit=%0d expected 0/0/0", out1, busy1, hit1);
    end
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (out1 !== 1'b0 || busy1 !== 1'b0 || hit1 !== 16'd0 || out0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle out=%b busy=%b hit=%0d expected 0/0/0", out1, busy1, hit1);
    end
    total++;
    if (dut1.state !== IDLE) begin
      bad++;
      $display("FAIL state_idle got=%0d expected %0d", dut1.state, IDLE);
    end
    en = 1'b1;
    @(negedge clk);
    total++;
    if (dut1.state !== HUNT) begin
      bad++;
      $display("FAIL state_hunt got=%0d expected %0d", dut1.state, HUNT);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [1:0] s [5] = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
    int h1 = mhit1;
    foreach (s[i]) begin
      drive_sym(s[i], 8);
      total++;
      if (busy1 !== (midx1 != 0) || busy0 !== (midx0 != 0)) begin
        bad++;
        $display("FAIL basic_busy step=%0d busy=%b/%b expected %b/%b", i, busy1, busy0,
                 midx1 != 0, midx0 != 0);
      end
    end
    total++;
    if (hit1 !== 16'(mhit1) || int'(hit1) - h1 != 1 || exp1.size() != 0) begin
      bad++;
      $display("FAIL basic_hit got=%0d expected %0d pending=%0d", hit1, mhit1, exp1.size());
    end
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_end got=%b expected 0", busy1);
    end
  endtask

  task automatic test_mismatch_restart();
    logic [1:0] s [7] = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd2};
    int h1 = mhit1;
    foreach (s[i]) begin
      drive_sym(s[i], 8);
      total++;
      if (busy1 !== (midx1 != 0)) begin
        bad++;
        $display("FAIL restart_busy step=%0d got=%b expected %b", i, busy1, midx1 != 0);
      end
    end
    total++;
    if (hit1 !== 16'(mhit1) || int'(hit1) - h1 != 1 || exp1.size() != 0) begin
      bad++;
      $display("FAIL restart_hit got=%0d expected %0d pending=%0d", hit1, mhit1, exp1.size());
    end
  endtask

  task automatic test_timeout();
    logic [1:0] s [5] = '{2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
    int hold [5] = '{8, 8, 28, 8, 8};
    int h1 = mhit1;
    foreach (s[i]) begin
      drive_sym(s[i], hold[i]);
      total++;
      if (busy1 !== (midx1 != 0) || busy0 !== (midx0 != 0)) begin
        bad++;
        $display("FAIL timeout_busy step=%0d busy=%b/%b expected %b/%b", i, busy1, busy0,
                 midx1 != 0, midx0 != 0);
      end
    end
    total++;
    if (hit1 !== 16'(h1)) begin
      bad++;
      $display("FAIL timeout_hit got=%0d expected %0d", hit1, h1);
    end
  endtask

  task automatic test_overlap();
    logic [1:0] p [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    logic [1:0] s [8] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};
    int h1 = mhit1;
    int h0 = mhit0;
    en = 1'b0;
    midx1 = 0; midx0 = 0;
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_idx = 2'(i); cfg_data = p[i];
      @(negedge clk);
      mpat[i] = p[i];
    end
    cfg_we = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    foreach (s[i]) begin
      drive_sym(s[i], 8);
      total++;
      if (busy1 !== (midx1 != 0) || busy0 !== (midx0 != 0)) begin
        bad++;
        $display("FAIL overlap_busy step=%0d busy=%b/%b expected %b/%b", i, busy1, busy0,
                 midx1 != 0, midx0 != 0);
      end
    end
    total++;
    if (int'(hit1) - h1 != 2 || hit1 !== 16'(mhit1)) begin
      bad++;
      $display("FAIL overlap1_hit got=%0d expected %0d", int'(hit1) - h1, 2);
    end
    total++;
    if (int'(hit0) - h0 != 1 || hit0 !== 16'(mhit0)) begin
      bad++;
      $display("FAIL overlap0_hit got=%0d expected %0d", int'(hit0) - h0, 1);
    end
  endtask

  task automatic test_cfg_locked();
    logic [1:0] s [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd2};
    int h1 = mhit1;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_data = 2'd3;
    @(negedge clk);
    cfg_idx = 2'd3; cfg_data = 2'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    foreach (s[i]) drive_sym(s[i], 8);
    total++;
    if (int'(hit1) - h1 != 1 || exp1.size() != 0) begin
      bad++;
      $display("FAIL cfg_locked_hit got=%0d expected %0d", int'(hit1) - h1, 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] a [3] = '{2'd0, 2'd2, 2'd1};
    logic [1:0] b [6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2};
    foreach (a[i]) drive_sym(a[i], 8);
    total++;
    if (busy1 !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy_before got=%b expected 1", busy1);
    end
    #2;
    rstn = 1'b0;
    din = 2'd0;
    #1;
    total++;
    if (busy1 !== 1'b0 || hit1 !== 16'd0 || out1 !== 1'b0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset busy=%b hit=%0d out=%b expected 0/0/0", busy1, hit1, out1);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    foreach (b[i]) drive_sym(b[i], 8);
    total++;
    if (hit1 !== 16'd1 || hit0 !== 16'd1 || exp1.size() != 0 || exp0.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_hit got=%0d/%0d expected 1/1", hit1, hit0);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] s [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    int h0 = mhit0;
    force dut1.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut1.cnt_q;
    mhit1 = 16'hFFFE;
    for (int r = 0; r < 3; r++) begin
      foreach (s[i]) drive_sym(s[i], 8);
    end
    total++;
    if (hit1 !== 16'hFFFF || hit1 !== 16'(mhit1)) begin
      bad++;
      $display("FAIL saturate got=%h expected ffff", hit1);
    end
    total++;
    if (int'(hit0) - h0 != 3 || exp1.size() != 0) begin
      bad++;
      $display("FAIL saturate_ref got=%0d expected %0d", int'(hit0) - h0, 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch_restart();
    test_timeout();
    test_overlap();
    test_cfg_locked();
    test_reset_mid();
    test_saturate();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter WIDTH, default 2: width of the asynchronous input symbol bus.
REQ-002 Parameter DEPTH, default 4: pattern length in symbols, legal range 2..16.
REQ-003 Parameter TIMEOUT, default 16: idle cycles after which a partial match is abandoned; 0 disables the timeout.
REQ-004 Parameter OVERLAP, default 1: 1 lets the final symbol of a match also start the next match.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rstn  input  1  reset; asynchronous, active-low.
REQ-007 in  input  WIDTH  asynchronous symbol inputs.
REQ-008 en  input  1  detector enable.
REQ-009 cfg_we  input  1  pattern write strobe.
REQ-010 cfg_idx  input  $clog2(DEPTH)  pattern slot to write.
REQ-011 cfg_data  input  WIDTH  pattern value to write.
REQ-012 out  output  1  one-cycle pulse on each completed match.
REQ-013 hit_cnt  output  16  saturating count of matches.
REQ-014 busy  output  1  high when the match index is greater than 0.

Function
REQ-015 in SHALL pass through a 2-flop synchronizer; a prev register SHALL hold the last synchronized value.
REQ-016 A symbol event SHALL occur in a cycle where the synchronized value differs from prev; held values are never events.
REQ-017 The FSM SHALL have states IDLE, HUNT and RUN, plus an index register idx in 0..DEPTH-1.
REQ-018 en=0 SHALL force IDLE with idx=0; prev SHALL keep tracking in IDLE.
REQ-019 en=1 in IDLE SHALL move to HUNT on the next edge.
REQ-020 In HUNT or RUN, an event with sym==pat[idx] and idx<DEPTH-1 SHALL increment idx, and the state SHALL be RUN.
REQ-021 An event with sym==pat[DEPTH-1] at idx=DEPTH-1 SHALL be a match: out=1 for exactly the next cycle, hit_cnt+1 saturating at 16'hFFFF.
REQ-022 After a match, idx SHALL become 1 if OVERLAP=1 and sym==pat[0], otherwise 0; the state SHALL be HUNT if idx=0, else RUN.
REQ-023 A mismatching event SHALL set idx to 1 if sym==pat[0], otherwise 0; the state SHALL follow the same rule.
REQ-024 In RUN, TIMEOUT consecutive cycles without an event SHALL set idx=0 and the state to HUNT; the timer SHALL clear on every event.
REQ-025 Latency: out SHALL rise on the 3rd rising edge after in changes (sync1, sync2, registered decision).
REQ-026 cfg_we=1 with en=0 SHALL write pat[cfg_idx]=cfg_data on the edge.
REQ-027 cfg_we with en=1 SHALL be ignored.
REQ-028 cfg_idx>=DEPTH SHALL be ignored.
REQ-029 busy SHALL equal (idx!=0), registered.

Reset
REQ-030 rstn=0 SHALL immediately clear sync flops, prev, idx, the timer, out, busy and hit_cnt to 0, and set the state to IDLE.
REQ-031 On reset, pat[k] SHALL be the Gray code of (k mod 2^WIDTH): 0,1,3,2 at the defaults.
REQ-032 Reset asserted mid-match SHALL discard the partial match and produce no pulse after release.

Structure
REQ-033 A package seq_detector_pkg SHALL hold the state enum (IDLE, HUNT, RUN), the 16-bit count width constant and the gray() function.
REQ-034 A sub-module sync2 (WIDTH-parametrised, async active-low reset) SHALL implement the synchronizer.

Verification (defaults unless noted; each symbol held 8 cycles; en=1)
REQ-035 Reset then idle for 20 cycles -> out=0, busy=0, hit_cnt=0, state IDLE until en=1.
REQ-036 in 3,0,1,3,2 -> exactly one out pulse on the 3rd edge after the change to 2; hit_cnt=1; busy=0 afterwards.
REQ-037 in 3,0,1,0,1,3,2 -> mismatch at the second 0 restarts idx at 1; one pulse; hit_cnt=1.
REQ-038 in 3,0,1, hold 20 cycles, then 3,2 -> timeout at 16 cycles drops busy; no pulse; hit_cnt=0.
REQ-039 With en=0, program pattern 2,1,3,2, then en=1 and drive in 0,2,1,3,2,1,3,2 -> OVERLAP=1: hit_cnt=2; OVERLAP=0: hit_cnt=1.
REQ-040 Write cfg with en=1 -> pattern unchanged. Assert rstn=0 at idx=2 -> no pulse after release. Force hit_cnt to 16'hFFFE, apply 3 matches -> hit_cnt=16'hFFFF.
